sample_extract_stream: RTL and testbench
========================================

SAMPLE_EXTRACT_STREAM -- requirements
Module: sample_extract_stream

Interface
REQ-001 Parameter K_PARAM, default 1: number of GLWE mask polynomials.
REQ-002 Parameter N_PARAM, default 1024: coefficients per polynomial; power of two, >= 2.
REQ-003 Parameter VALUE_SIZE, default 32: coefficient width; arithmetic is mod 2^VALUE_SIZE.
REQ-004 Parameter ADDR_W, default $clog2(K_PARAM*N_PARAM+1): LWE output index width.
REQ-005 clk_in  input  1  sole clock, rising edge.
REQ-006 rst_in  input  1  asynchronous, active-high reset.
REQ-007 start_in  input  1  begin frame; honoured only in IDLE.
REQ-008 h_in  input  $clog2(N_PARAM)  extraction index; sampled when start_in is honoured.
REQ-009 value_in  input  VALUE_SIZE  GLWE coefficient, stream order: A_0[0..N-1], ..., A_{K-1}[0..N-1], B[0..N-1].
REQ-010 valid_in  input  1  value_in valid.
REQ-011 ready_out  output  1  block accepts value_in this cycle.
REQ-012 data_out  output  VALUE_SIZE  LWE coefficient.
REQ-013 addr_out  output  ADDR_W  LWE index; K*N denotes body b.
REQ-014 valid_out  output  1  data_out/addr_out valid.
REQ-015 ready_in  input  1  downstream accepts output.
REQ-016 busy_out  output  1  high outside IDLE.
REQ-017 done_out  output  1  one-cycle pulse at frame completion.

Function
REQ-018 FSM states IDLE, MASK, BODY, DRAIN; IDLE->MASK on start_in; MASK->BODY after K*N mask beats accepted; BODY->DRAIN after N body beats accepted; DRAIN->IDLE when the output register is empty or emptying (valid_out=0, or valid_out=1 with ready_in=1).
REQ-019 A beat is accepted when valid_in && ready_out; ready_out = (state is MASK or BODY) && (!valid_out || ready_in).
REQ-020 Counters: poly index i (0..K-1) and coefficient index m (0..N-1); m wraps N-1->0 and increments i on wrap; both clear on start.
REQ-021 Mask beat m of polynomial i with m <= h: addr_out = i*N + (h-m), data_out = value_in.
REQ-022 Mask beat with m > h: addr_out = i*N + (N+h-m), data_out = two's-complement negation of value_in mod 2^VALUE_SIZE (0 maps to 0).
REQ-023 Body beat m == h: addr_out = K*N, data_out = value_in unmodified; all other body beats are accepted and discarded (valid_out not asserted).
REQ-024 Latency: exactly one cycle from accepted beat to valid_out; a single output register holds data_out/addr_out/valid_out stable while valid_out && !ready_in.
REQ-025 Throughput: one beat per cycle under continuous valid_in and ready_in.
REQ-026 done_out pulses in the cycle the FSM leaves DRAIN.
REQ-027 start_in while busy_out is ignored; h_in is not resampled mid-frame.
REQ-028 Each frame emits exactly K*N+1 outputs, each LWE index exactly once.

Reset
REQ-029 On rst_in (any cycle, including mid-frame): state=IDLE, counters=0, latched h=0, valid_out=0, data_out=0, addr_out=0, done_out=0, busy_out=0, ready_out=0; the partial frame is discarded.

Structure
REQ-030 Package tfhe_pkg holds the FSM state enum and the negate-mod-2^VALUE_SIZE helper function.
REQ-031 One sub-module, se_out_reg: the valid/ready output register stage.

Verification
REQ-032 K=1,N=4,h=0, A=[1,2,3,4], B=[5,6,7,8], ready_in=1 -> (0,1),(3,0xFFFFFFFE),(2,0xFFFFFFFD),(1,0xFFFFFFFC),(4,5); done_out pulses once.
REQ-033 K=2,N=4,h=2, A_0=[1,2,3,4], A_1=[9,10,11,12], B=[5,6,7,8] -> (2,1),(1,2),(0,3),(3,0xFFFFFFFC),(6,9),(5,10),(4,11),(7,0xFFFFFFF4),(8,7).
REQ-034 Same as REQ-032 with ready_in low for cycles 2-4 -> outputs held stable, ready_out=0 during stall, identical sequence, no loss or duplication.
REQ-035 Mask coefficient 0 at m > h -> data_out=0; coefficient 0x80000000 at m > h -> data_out=0x80000000.
REQ-036 rst_in asserted after the third mask beat, then a new frame with h=3 -> no residual outputs, new frame correct per REQ-021..023.
REQ-037 start_in pulsed mid-frame with a different h_in -> ignored; output matches the original h.

Source files
------------

// File: rtl/tfhe_pkg.sv
// Shared types and helpers for the TFHE sample-extract stream block.
// Holds the frame FSM state encoding and the modular negate helper.
package tfhe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MASK,
        ST_BODY,
        ST_DRAIN
    } se_state_e;

    // Two's-complement negation; callers truncate to their coefficient
    // width, which yields negation mod 2^width (0 stays 0).
    function automatic logic [63:0] neg_mod(input logic [63:0] v);
        return (~v) + 64'd1;
    endfunction

endpackage

// File: rtl/se_out_reg.sv
// Single-entry valid/ready output register for the sample-extract stream.
// Ports: load_* from the extract logic, can_load_out back-pressure,
// valid_out/data_out/addr_out held stable until ready_in.
module se_out_reg #(
    parameter int W  = 32,
    parameter int AW = 11
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          load_valid_in,
    input  logic [W-1:0]  load_data_in,
    input  logic [AW-1:0] load_addr_in,
    output logic          can_load_out,
    input  logic          ready_in,
    output logic          valid_out,
    output logic [W-1:0]  data_out,
    output logic [AW-1:0] addr_out
);

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;

    assign can_load_out = !valid_q || ready_in;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        if (can_load_out) begin
            valid_d = load_valid_in;
            if (load_valid_in) begin
                data_d = load_data_in;
                addr_d = load_addr_in;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign addr_out  = addr_q;

endmodule

// File: rtl/sample_extract_stream.sv
// Streaming GLWE-to-LWE sample extraction at index h.
// Ports: start_in/h_in begin a frame, value_in/valid_in/ready_out input
// stream, data_out/addr_out/valid_out/ready_in output stream, busy/done.
module sample_extract_stream
    import tfhe_pkg::*;
#(
    parameter int K_PARAM    = 1,
    parameter int N_PARAM    = 1024,
    parameter int VALUE_SIZE = 32,
    parameter int ADDR_W     = $clog2(K_PARAM*N_PARAM+1)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start_in,
    input  logic [$clog2(N_PARAM)-1:0] h_in,
    input  logic [VALUE_SIZE-1:0]      value_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [VALUE_SIZE-1:0]      data_out,
    output logic [ADDR_W-1:0]          addr_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       busy_out,
    output logic                       done_out
);

    localparam int LN = $clog2(N_PARAM);
    localparam int IW = (K_PARAM > 1) ? $clog2(K_PARAM) : 1;
    localparam logic [ADDR_W-1:0] BODY_ADDR = ADDR_W'(K_PARAM*N_PARAM);
    localparam logic [LN-1:0] M_LAST = LN'(N_PARAM-1);
    localparam logic [IW-1:0] I_LAST = IW'(K_PARAM-1);

    se_state_e state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [LN-1:0] m_q, m_d;
    logic [LN-1:0] h_q, h_d;

    logic                  can_load;
    logic                  accept;
    logic                  emit;
    logic [VALUE_SIZE-1:0] emit_data;
    logic [ADDR_W-1:0]     emit_addr;
    logic [LN-1:0]         off;
    logic [ADDR_W-1:0]     mask_addr;
    logic                  done;

    assign ready_out = ((state_q == ST_MASK) || (state_q == ST_BODY))
                       && can_load;
    assign accept    = valid_in && ready_out;

    // (h - m) mod N covers both the m <= h and the wrapped m > h case.
    assign off       = h_q - m_q;
    assign mask_addr = ADDR_W'(i_q) * ADDR_W'(N_PARAM) + ADDR_W'(off);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        m_d       = m_q;
        h_d       = h_q;
        emit      = 1'b0;
        emit_data = value_in;
        emit_addr = '0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_MASK;
                    i_d     = '0;
                    m_d     = '0;
                    h_d     = h_in;
                end
            end
            ST_MASK: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_addr = mask_addr;
                    if (m_q > h_q) begin
                        emit_data = VALUE_SIZE'(neg_mod(64'(value_in)));
                    end
                    if (m_q == M_LAST) begin
                        m_d = '0;
                        if (i_q == I_LAST) begin
                            i_d     = '0;
                            state_d = ST_BODY;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        m_d = m_q + LN'(1);
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    emit      = (m_q == h_q);
                    emit_addr = BODY_ADDR;
                    if (m_q == M_LAST) begin
                        m_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        m_d = m_q + LN'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (can_load) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            m_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            m_q     <= m_d;
            h_q     <= h_d;
        end
    end

    se_out_reg #(
        .W  (VALUE_SIZE),
        .AW (ADDR_W)
    ) u_out (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load_valid_in (emit),
        .load_data_in  (emit_data),
        .load_addr_in  (emit_addr),
        .can_load_out  (can_load),
        .ready_in      (ready_in),
        .valid_out     (valid_out),
        .data_out      (data_out),
        .addr_out      (addr_out)
    );

    assign busy_out = (state_q != ST_IDLE);
    assign done_out = done;

endmodule

// File: tb/tb_sample_extract_stream.sv
// Directed bench for sample_extract_stream: K=1,N=4 and K=2,N=4 instances.
// Outputs are collected at negedge and compared to hand-computed tables.
module tb_sample_extract_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 0, a_vin = 0, a_rdy_in = 1;
    logic [1:0]  a_h = 0;
    logic [31:0] a_val = 0;
    logic        a_rdy_out, a_vout, a_busy, a_done;
    logic [31:0] a_data;
    logic [2:0]  a_addr;

    logic        b_start = 0, b_vin = 0, b_rdy_in = 1;
    logic [1:0]  b_h = 0;
    logic [31:0] b_val = 0;
    logic        b_rdy_out, b_vout, b_busy, b_done;
    logic [31:0] b_data;
    logic [3:0]  b_addr;

    sample_extract_stream #(.K_PARAM(1), .N_PARAM(4)) dut_a (
        .clk_in(clk), .rst_in(rst), .start_in(a_start), .h_in(a_h),
        .value_in(a_val), .valid_in(a_vin), .ready_out(a_rdy_out),
        .data_out(a_data), .addr_out(a_addr), .valid_out(a_vout),
        .ready_in(a_rdy_in), .busy_out(a_busy), .done_out(a_done)
    );

    sample_extract_stream #(.K_PARAM(2), .N_PARAM(4)) dut_b (
        .clk_in(clk), .rst_in(rst), .start_in(b_start), .h_in(b_h),
        .value_in(b_val), .valid_in(b_vin), .ready_out(b_rdy_out),
        .data_out(b_data), .addr_out(b_addr), .valid_out(b_vout),
        .ready_in(b_rdy_in), .busy_out(b_busy), .done_out(b_done)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          done_cnt = 0;
    logic        hold_p = 0;
    logic [2:0]  p_addr = 0;
    logic [31:0] p_data = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_vout && a_rdy_in) begin
                got_addr.push_back(32'(a_addr));
                got_data.push_back(a_data);
            end
            if (b_vout && b_rdy_in) begin
                got_addr.push_back(32'(b_addr));
                got_data.push_back(b_data);
            end
            if (a_done || b_done) done_cnt <= done_cnt + 1;
            if (hold_p) begin
                chk("hold_addr", 64'(a_addr), 64'(p_addr));
                chk("hold_data", 64'(a_data), 64'(p_data));
            end
            if (a_vout && !a_rdy_in) begin
                chk("stall_ready_out", 64'(a_rdy_out), 64'd0);
            end
            hold_p <= a_vout && !a_rdy_in;
            p_addr <= a_addr;
            p_data <= a_data;
        end else begin
            hold_p <= 1'b0;
        end
    end

    logic [31:0] vec[12];
    int          ex_addr[$];
    logic [31:0] ex_data[$];

    task automatic run(input bit sel, input int nb, input logic [1:0] h,
                       input int st_lo, input int st_hi,
                       input int mid_at, input bit fin);
        int idx;
        int cyc;
        bit acc;
        @(posedge clk); #1;
        if (sel) begin b_start = 1; b_h = h; end
        else begin a_start = 1; a_h = h; end
        @(posedge clk); #1;
        a_start = 0;
        b_start = 0;
        idx = 0;
        cyc = 0;
        while (idx < nb && cyc < 200) begin
            if (sel) begin b_vin = 1; b_val = vec[idx]; end
            else begin a_vin = 1; a_val = vec[idx]; end
            a_rdy_in = !(cyc >= st_lo && cyc <= st_hi);
            if (sel) begin
                b_start = (cyc == mid_at);
                b_h = (cyc == mid_at) ? 2'd1 : h;
            end
            @(negedge clk);
            acc = sel ? b_rdy_out : a_rdy_out;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        a_vin = 0;
        b_vin = 0;
        b_start = 0;
        a_rdy_in = 1;
        if (cyc >= 200) chk("beat_timeout", 64'(idx), 64'(nb));
        if (fin) begin
            cyc = 0;
            while ((sel ? b_busy : a_busy) && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("frame_end_busy", 64'(sel ? b_busy : a_busy), 64'd0);
        end
    endtask

    task automatic check_frame(input string name, input int base,
                               input int dbase);
        chk({name, "_count"}, 64'(got_addr.size() - base),
            64'(ex_addr.size()));
        for (int i = 0; i < ex_addr.size(); i++) begin
            if (base + i < got_addr.size()) begin
                chk($sformatf("%s_addr%0d", name, i),
                    64'(got_addr[base+i]), 64'(ex_addr[i]));
                chk($sformatf("%s_data%0d", name, i),
                    64'(got_data[base+i]), 64'(ex_data[i]));
            end
        end
        chk({name, "_done"}, 64'(done_cnt - dbase), 64'd1);
    endtask

    task automatic check_reset();
        chk("rst_a_valid", 64'(a_vout), 64'd0);
        chk("rst_a_data", 64'(a_data), 64'd0);
        chk("rst_a_addr", 64'(a_addr), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_ready", 64'(a_rdy_out), 64'd0);
        chk("rst_a_done", 64'(a_done), 64'd0);
        chk("rst_b_valid", 64'(b_vout), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);
    endtask

    int base;
    int dbase;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst = 0;

        vec = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
        ex_addr = {0, 3, 2, 1, 4};
        ex_data = {32'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'd5};
        base = got_addr.size();
        dbase = done_cnt;
        run(0, 8, 2'd0, -1, -1, -1, 1);
        check_frame("k1h0", base, dbase);

        base = got_addr.size();
        dbase = done_cnt;
        run(0, 8, 2'd0, 2, 4, -1, 1);
        check_frame("stall", base, dbase);

        vec = '{7, 0, 32'h80000000, 5, 9, 6, 7, 8, 0, 0, 0, 0};
        ex_addr = {0, 3, 2, 1, 4};
        ex_data = {32'd7, 32'd0, 32'h80000000, 32'hFFFFFFFB, 32'd9};
        base = got_addr.size();
        dbase = done_cnt;
        run(0, 8, 2'd0, -1, -1, -1, 1);
        check_frame("negedge", base, dbase);

        vec = '{1, 2, 3, 4, 9, 10, 11, 12, 5, 6, 7, 8};
        ex_addr = {2, 1, 0, 3, 6, 5, 4, 7, 8};
        ex_data = {32'd1, 32'd2, 32'd3, 32'hFFFFFFFC,
                   32'd9, 32'd10, 32'd11, 32'hFFFFFFF4, 32'd7};
        base = got_addr.size();
        dbase = done_cnt;
        run(1, 12, 2'd2, -1, -1, -1, 1);
        check_frame("k2h2", base, dbase);

        base = got_addr.size();
        dbase = done_cnt;
        run(1, 12, 2'd2, -1, -1, 3, 1);
        check_frame("midstart", base, dbase);
        @(posedge clk); #1;
        chk("midstart_idle", 64'(b_busy), 64'd0);

        vec = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
        run(0, 3, 2'd0, -1, -1, -1, 0);
        rst = 1;
        #1;
        check_reset();
        @(posedge clk); #1;
        rst = 0;
        ex_addr = {3, 2, 1, 0, 4};
        ex_data = {32'd1, 32'd2, 32'd3, 32'd4, 32'd8};
        base = got_addr.size();
        dbase = done_cnt;
        run(0, 8, 2'd3, -1, -1, -1, 1);
        check_frame("postrst", base, dbase);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
